// File: rtl/hazard_halt_unit_pkg.sv
// Shared types and constants for the hazard/halt unit: shadow slot layout,
// halt FSM states and the register indices the hazard compare cares about.
package hazard_halt_unit_pkg;

  localparam int          HALT_CODE_DEF = 10;
  localparam int          ECALL_REG_DEF = 17;
  localparam logic [4:0]  REG_X0        = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, rd: REG_X0, reg_write: 1'b0, mem_read: 1'b0};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // x0 is hardwired, so a write to it can never be a producer.
  function automatic logic slot_hit(input slot_t s, input logic [4:0] src);
    return s.valid & s.reg_write & (s.rd != REG_X0) & (s.rd == src);
  endfunction

endpackage

// File: rtl/hazard_halt_unit_slot_pipe.sv
// Three-deep shadow of the EX/MEM/WB destination fields; a bubble enters EX
// whenever the ID instruction does not advance.
module hazard_slot_pipe
  import hazard_halt_unit_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_load,
  input  slot_t i_slot,
  output slot_t o_ex,
  output slot_t o_mem,
  output slot_t o_wb
);

  slot_t r_ex;
  slot_t r_mem;
  slot_t r_wb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex  <= SLOT_BUBBLE;
      r_mem <= SLOT_BUBBLE;
      r_wb  <= SLOT_BUBBLE;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= i_load ? i_slot : SLOT_BUBBLE;
    end
  end

  assign o_ex  = r_ex;
  assign o_mem = r_mem;
  assign o_wb  = r_wb;

endmodule

// File: rtl/hazard_halt_unit.sv
// ID-side hazard detector: load-use and ecall/x17 stalls, plus the halt
// ecall drain sequence and a saturating stall-cycle counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal issue; stalls evaluated, halt ecall detected
// ST_DRAIN  | halt seen; fetch frozen while older instructions retire
// ST_HALTED | terminal until reset; is_halted asserted
module hazard_halt_unit
  import hazard_halt_unit_pkg::*;
#(
  parameter int HALT_CODE    = HALT_CODE_DEF,
  parameter int ECALL_REG    = ECALL_REG_DEF,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_is_ecall,
  input  logic [31:0]      id_x17_data,
  input  logic             flush,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             halt_pending,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int          DCNT_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [4:0]  ECALL_IDX  = 5'(ECALL_REG);
  localparam logic [31:0] HALT_VAL   = 32'(HALT_CODE);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DCNT_W-1:0]  r_drain_cnt;
  logic [DCNT_W-1:0]  w_drain_cnt_nxt;
  logic [CNT_W-1:0]   r_stall_count;

  slot_t w_ex;
  slot_t w_mem;
  slot_t w_wb;
  slot_t w_id_slot;
  logic  w_unused_wb;

  logic w_run;
  logic w_load_use;
  logic w_ecall_hz;
  logic w_stall;
  logic w_halt_detect;
  logic w_ex_load;

  assign w_run = (r_state == ST_RUN);

  assign w_load_use = w_ex.mem_read &
                      ((id_use_rs1 & slot_hit(w_ex, id_rs1)) |
                       (id_use_rs2 & slot_hit(w_ex, id_rs2)));

  // x17 from an ALU op in EX is not yet forwardable to ID; a load in MEM
  // still has no data, so it costs a second cycle.
  assign w_ecall_hz = id_is_ecall &
                      (slot_hit(w_ex, ECALL_IDX) |
                       (w_mem.mem_read & slot_hit(w_mem, ECALL_IDX)));

  assign w_stall = id_valid & w_run & ~flush & (w_load_use | w_ecall_hz);

  assign w_halt_detect = w_run & id_valid & id_is_ecall & ~w_stall & ~flush &
                         (id_x17_data == HALT_VAL);

  // The halting ecall itself is not tracked; it enters EX as a bubble.
  assign w_ex_load = id_valid & ~w_stall & ~flush & w_run & ~w_halt_detect;

  assign w_id_slot = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

  hazard_slot_pipe u_slot_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_ex_load),
    .i_slot (w_id_slot),
    .o_ex   (w_ex),
    .o_mem  (w_mem),
    .o_wb   (w_wb)
  );

  assign w_unused_wb = ^w_wb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_halt_detect) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - DCNT_W'(1);
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_drain_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall        = w_stall;
  assign halt_pending = ~w_run;
  assign is_halted    = (r_state == ST_HALTED);
  assign pc_write     = ~w_stall & w_run;
  assign if_id_write  = ~w_stall & w_run;
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_halt_unit.sv
// Directed self-checking bench for hazard_halt_unit; the stall counter is
// narrowed to 4 bits so saturation is reachable in a short run.
module tb_hazard_halt_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_is_ecall;
  logic [31:0]      id_x17_data;
  logic             flush;
  logic             stall;
  logic             pc_write;
  logic             if_id_write;
  logic             halt_pending;
  logic             is_halted;
  logic [CNT_W-1:0] stall_count;

  int n_pass  = 0;
  int n_total = 0;

  hazard_halt_unit #(
    .HALT_CODE    (10),
    .ECALL_REG    (17),
    .DRAIN_CYCLES (3),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_is_ecall  (id_is_ecall),
    .id_x17_data  (id_x17_data),
    .flush        (flush),
    .stall        (stall),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .halt_pending (halt_pending),
    .is_halted    (is_halted),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; id_is_ecall = 0;
    id_x17_data = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic ec,
                           input logic [31:0] x17);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_is_ecall = ec;
    id_x17_data = x17;
  endtask

  task automatic do_reset();
    reset = 1; flush = 0;
    set_nop();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (pc_write !== 1'b1) $display("FAIL rst_pc_write: got %b want 1", pc_write); else n_pass++;
    n_total++; if (if_id_write !== 1'b1) $display("FAIL rst_if_id_write: got %b want 1", if_id_write); else n_pass++;
    n_total++; if (halt_pending !== 1'b0) $display("FAIL rst_halt_pending: got %b want 0", halt_pending); else n_pass++;
    n_total++; if (is_halted !== 1'b0) $display("FAIL rst_is_halted: got %b want 0", is_halted); else n_pass++;
    n_total++; if (stall_count !== 4'd0) $display("FAIL rst_stall_count: got %0d want 0", stall_count); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);     // lw x5
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL lu_lw_stall: got %b want 0", stall); else n_pass++;
    tick();
    set_instr(5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0);     // add x6,x5,x1
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall); else n_pass++;
    n_total++; if (pc_write !== 1'b0) $display("FAIL lu_pc_write: got %b want 0", pc_write); else n_pass++;
    n_total++; if (if_id_write !== 1'b0) $display("FAIL lu_if_id_write: got %b want 0", if_id_write); else n_pass++;
    tick();
    n_total++; if (stall !== 1'b0) $display("FAIL lu_stall_2nd: got %b want 0", stall); else n_pass++;
    n_total++; if (pc_write !== 1'b1) $display("FAIL lu_pc_write_2nd: got %b want 1", pc_write); else n_pass++;
    tick();
    set_nop();
    n_total++; if (stall_count !== 4'd1) $display("FAIL lu_count: got %0d want 1", stall_count); else n_pass++;
    // rs2 hazard path
    set_instr(5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 0, 0);     // lw x9
    tick();
    set_instr(5'd1, 5'd9, 1, 1, 5'd3, 1, 0, 0, 0);     // sub x3,x1,x9
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL lu_rs2_stall: got %b want 1", stall); else n_pass++;
    tick();
    set_nop();
  endtask

  task automatic test_no_use();
    do_reset();
    set_instr(5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);     // lw x5
    tick();
    set_instr(5'd5, 5'd1, 0, 1, 5'd6, 1, 0, 0, 0);     // rs1=5 but not read
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL nouse_stall: got %b want 0", stall); else n_pass++;
    tick();
    set_instr(5'd2, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0);     // lw x0
    tick();
    set_instr(5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 0, 0);     // reads x0
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL x0_stall: got %b want 0", stall); else n_pass++;
    tick();
    set_instr(5'd2, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0);     // addi x7 (not a load)
    tick();
    set_instr(5'd7, 5'd0, 1, 0, 5'd8, 1, 0, 0, 0);
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL alu_nostall: got %b want 0", stall); else n_pass++;
    tick();
    set_nop();
  endtask

  task automatic test_ecall_halt();
    do_reset();
    set_instr(5'd0, 5'd0, 1, 0, 5'd17, 1, 0, 0, 0);    // addi x17,x0,10
    tick();
    set_instr(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'd10); // ecall
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL ec_stall: got %b want 1", stall); else n_pass++;
    tick();
    n_total++; if (stall !== 1'b0) $display("FAIL ec_stall_2nd: got %b want 0", stall); else n_pass++;
    n_total++; if (halt_pending !== 1'b0) $display("FAIL ec_pend_early: got %b want 0", halt_pending); else n_pass++;
    tick();                                             // detecting edge
    set_nop();
    n_total++; if (halt_pending !== 1'b1) $display("FAIL ec_pend: got %b want 1", halt_pending); else n_pass++;
    n_total++; if (pc_write !== 1'b0) $display("FAIL ec_pc_write: got %b want 0", pc_write); else n_pass++;
    n_total++; if (is_halted !== 1'b0) $display("FAIL ec_halt_e0: got %b want 0", is_halted); else n_pass++;
    tick();
    n_total++; if (is_halted !== 1'b0) $display("FAIL ec_halt_e1: got %b want 0", is_halted); else n_pass++;
    tick();
    n_total++; if (is_halted !== 1'b0) $display("FAIL ec_halt_e2: got %b want 0", is_halted); else n_pass++;
    tick();
    n_total++; if (is_halted !== 1'b1) $display("FAIL ec_halt_e3: got %b want 1", is_halted); else n_pass++;
    flush = 1;
    set_instr(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'd10);
    tick();
    flush = 0;
    set_nop();
    n_total++; if (is_halted !== 1'b1) $display("FAIL ec_halt_hold: got %b want 1", is_halted); else n_pass++;
    n_total++; if (stall_count !== 4'd1) $display("FAIL ec_count: got %0d want 1", stall_count); else n_pass++;
  endtask

  task automatic test_load_x17_ecall();
    do_reset();
    set_instr(5'd2, 5'd0, 1, 0, 5'd17, 1, 1, 0, 0);    // lw x17
    tick();
    set_instr(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'd5);  // ecall, non-halt code
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL lx_stall_1: got %b want 1", stall); else n_pass++;
    tick();
    n_total++; if (stall !== 1'b1) $display("FAIL lx_stall_2: got %b want 1", stall); else n_pass++;
    tick();
    n_total++; if (stall !== 1'b0) $display("FAIL lx_stall_3: got %b want 0", stall); else n_pass++;
    tick();
    set_nop();
    n_total++; if (stall_count !== 4'd2) $display("FAIL lx_count: got %0d want 2", stall_count); else n_pass++;
    n_total++; if (halt_pending !== 1'b0) $display("FAIL lx_no_halt: got %b want 0", halt_pending); else n_pass++;
    tick();
    tick();
    tick();
    n_total++; if (is_halted !== 1'b0) $display("FAIL lx_no_halted: got %b want 0", is_halted); else n_pass++;
    n_total++; if (pc_write !== 1'b1) $display("FAIL lx_pc_write: got %b want 1", pc_write); else n_pass++;
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    set_instr(5'd0, 5'd0, 1, 0, 5'd17, 1, 0, 0, 0);
    tick();
    set_instr(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 32'd10);
    tick();                                             // stalled cycle
    tick();                                             // detect edge
    set_nop();
    tick();                                             // drain_cnt now 1
    n_total++; if (halt_pending !== 1'b1) $display("FAIL rd_pend: got %b want 1", halt_pending); else n_pass++;
    reset = 1;
    tick();
    reset = 0;
    n_total++; if (halt_pending !== 1'b0) $display("FAIL rd_pend_clr: got %b want 0", halt_pending); else n_pass++;
    n_total++; if (is_halted !== 1'b0) $display("FAIL rd_halted: got %b want 0", is_halted); else n_pass++;
    n_total++; if (stall_count !== 4'd0) $display("FAIL rd_count: got %0d want 0", stall_count); else n_pass++;
    n_total++; if (pc_write !== 1'b1) $display("FAIL rd_pc_write: got %b want 1", pc_write); else n_pass++;
    tick();
    tick();
    n_total++; if (is_halted !== 1'b0) $display("FAIL rd_halted_late: got %b want 0", is_halted); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    set_instr(5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);
    tick();
    flush = 1;
    set_instr(5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0);
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL fl_stall: got %b want 0", stall); else n_pass++;
    tick();
    flush = 0;
    n_total++; if (stall_count !== 4'd0) $display("FAIL fl_count: got %0d want 0", stall_count); else n_pass++;
    // a flushed load must leave a bubble in ex
    flush = 1;
    set_instr(5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);
    tick();
    flush = 0;
    set_instr(5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0);
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL fl_bubble: got %b want 0", stall); else n_pass++;
    tick();
    set_nop();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      set_instr(5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0);
      tick();
      set_instr(5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0);
      tick();
      tick();
      if (exp_cnt < 15) exp_cnt++;
      n_total++;
      if (stall_count !== 4'(exp_cnt))
        $display("FAIL sat_count[%0d]: got %0d want %0d", i, stall_count, exp_cnt);
      else n_pass++;
    end
    set_nop();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_use();
    test_ecall_halt();
    test_load_x17_ecall();
    test_reset_in_drain();
    test_flush();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_halt_unit.md
Name: hazard_halt_unit

Overview:
- Producer-side counterpart to the ecall/operand forwarding path in the 5-stage pipelined RISC-V core.
- Tracks in-flight destination registers in shadow EX/MEM/WB slots and raises stalls when a consumer in ID cannot be served by forwarding: load-use, and ecall reading x17.
- Detects the halt ecall (x17 == HALT_CODE), drains older instructions and asserts is_halted.
- Sits beside the ID stage; drives PC/IF-ID write enables and ID/EX bubble insertion.

Parameters:
HALT_CODE, 10, x17 value that makes ecall a halt
ECALL_REG, 17, register index read by ecall
DRAIN_CYCLES, 3, cycles from halt detect to is_halted (lets EX/MEM/WB retire)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  ID source 1 index
id_rs2  in  5  ID source 2 index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  5  ID destination index
id_reg_write  in  1  ID instruction writes rd
id_mem_read  in  1  ID instruction is a load
id_is_ecall  in  1  ID instruction is ecall
id_x17_data  in  32  forwarded x17 value at ID
flush  in  1  branch-mispredict flush of IF/ID and ID/EX
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
pc_write  out  1  ~stall & ~halt_pending
if_id_write  out  1  ~stall & ~halt_pending
halt_pending  out  1  FSM in DRAIN or HALTED
is_halted  out  1  FSM in HALTED
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Shadow slots ex/mem/wb each hold {valid, rd, reg_write, mem_read}. Each cycle: wb<=mem, mem<=ex. ex<=ID fields if id_valid & ~stall & ~flush & state==RUN; otherwise ex<=bubble (valid=0).
- Hit rule: slot valid, reg_write, rd != 0 and rd equal to the relevant source.
- Load-use: ex slot is a load and hits (id_use_rs1 & rs1) or (id_use_rs2 & rs2) -> stall.
- Ecall-x17:
  - id_is_ecall and the ex slot hits ECALL_REG (any write) -> stall.
  - id_is_ecall and the mem slot is a load hitting ECALL_REG -> stall.
  - A load to x17 immediately before ecall therefore gives 2 consecutive stall cycles.
- stall is combinational from the slots and ID inputs, gated with id_valid & state==RUN; it is forced 0 when flush=1 (flush wins).
- FSM RUN -> DRAIN: in RUN, when id_valid & id_is_ecall & ~stall & ~flush & id_x17_data==HALT_CODE.
  - The ecall itself enters ex as a bubble.
  - drain_cnt loads DRAIN_CYCLES-1.
- FSM DRAIN: drain_cnt decrements each cycle; at 0 -> HALTED.
- FSM HALTED: terminal until reset; slots keep shifting bubbles.
- An ecall with x17 != HALT_CODE passes as a normal instruction.
- flush in DRAIN or HALTED is ignored.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Reset (synchronous, valid at any state including mid-DRAIN):
  - all slots invalid, state=RUN, drain_cnt=0, stall_count=0.
  - Outputs after reset: stall=0, pc_write=1, if_id_write=1, halt_pending=0, is_halted=0.
- Latency: stall is 0-cycle (same cycle as ID inputs). is_halted rises exactly DRAIN_CYCLES clock edges after the detecting edge.
- x0 never causes a hazard.

Decomposition:
- Shared package holds:
  - slot struct {valid, rd[4:0], reg_write, mem_read}
  - FSM state enum {RUN, DRAIN, HALTED}
  - HALT_CODE and ECALL_REG defaults
  - constant REG_X0 = 5'd0
- One natural sub-module: hazard_slot_pipe (3-deep shadow slot shift register with bubble insert). Hazard compare and FSM stay in the top level.

Test Plan:
- lw x5 then add x6,x5,x1 back-to-back -> stall=1 for exactly 1 cycle; pc_write=0 that cycle; stall_count=1.
- lw x5 followed by an instruction with id_use_rs1=0 reading rs1=5 -> stall=0.
- addi x17 then ecall (id_x17_data=10) -> 1 stall; ecall then issues; halt_pending=1 next cycle; is_halted=1 three edges after detect.
- lw x17 then ecall -> stall high 2 consecutive cycles; stall_count=2.
- ecall with id_x17_data=5 -> no halt; state stays RUN.
- In DRAIN: assert reset with drain_cnt=1 -> next cycle state RUN, is_halted=0, stall_count=0.
- Load-use hazard with flush=1 in the same cycle -> stall=0, ex slot bubble.
- Force stall_count to all-ones, then stall -> value holds.
